// File: rtl/rect_painter.sv
// Rectangle painter: drives VGA adapter pixel writes to fill a clipped
// rectangle in raster order, one pixel per clock.
module rect_painter #(
    parameter RESOLUTION = "640x480",
    parameter int COLOR_DEPTH = 9,
    parameter int nX = (RESOLUTION == "640x480") ? 10 : (RESOLUTION == "320x240") ? 9 : 8,
    parameter int nY = (RESOLUTION == "640x480") ? 9 : (RESOLUTION == "320x240") ? 8 : 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [nX-1:0]          x0,
    input  logic [nY-1:0]          y0,
    input  logic [nX-1:0]          w,
    input  logic [nY-1:0]          h,
    input  logic [COLOR_DEPTH-1:0] fill_color,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] color,
    output logic                   write
);

    localparam int XMAX = (RESOLUTION == "640x480") ? 640 : (RESOLUTION == "320x240") ? 320 : 160;
    localparam int YMAX = (RESOLUTION == "640x480") ? 480 : (RESOLUTION == "320x240") ? 240 : 120;
    localparam logic [nX:0] XMAX_V = XMAX[nX:0];
    localparam logic [nY:0] YMAX_V = YMAX[nY:0];

    typedef enum logic [1:0] {
        IDLE,
        CLIP,
        DRAW,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [nX-1:0]          x0_q, x0_d;
    logic [nY-1:0]          y0_q, y0_d;
    logic [nX-1:0]          w_q, w_d;
    logic [nY-1:0]          h_q, h_d;
    logic [nX:0]            xe_q, xe_d;
    logic [nY:0]            ye_q, ye_d;
    logic [nX-1:0]          x_d;
    logic [nY-1:0]          y_d;
    logic [COLOR_DEPTH-1:0] color_d;
    logic                   write_d, done_d, busy_d;

    // One extra bit on every sum so the clip compare never sees a wrapped value
    logic [nX:0] x_sum, x_nx;
    logic [nY:0] y_sum, y_nx;

    assign x_sum = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum = {1'b0, y0_q} + {1'b0, h_q};
    assign x_nx  = {1'b0, x} + {{nX{1'b0}}, 1'b1};
    assign y_nx  = {1'b0, y} + {{nY{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        x_d     = x;
        y_d     = y;
        color_d = color;
        write_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    w_d     = w;
                    h_d     = h;
                    color_d = fill_color;
                    state_d = CLIP;
                end
            end
            CLIP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    xe_d = (x_sum > XMAX_V) ? XMAX_V : x_sum;
                    ye_d = (y_sum > YMAX_V) ? YMAX_V : y_sum;
                    if (w_q == '0 || h_q == '0 ||
                        {1'b0, x0_q} >= XMAX_V || {1'b0, y0_q} >= YMAX_V) begin
                        state_d = DONE;
                    end else begin
                        x_d     = x0_q;
                        y_d     = y0_q;
                        write_d = 1'b1;
                        state_d = DRAW;
                    end
                end
            end
            DRAW: begin
                // The pixel presented this cycle is written regardless of abort
                if (abort) begin
                    state_d = IDLE;
                end else if (x_nx < xe_q) begin
                    x_d     = x_nx[nX-1:0];
                    write_d = 1'b1;
                end else if (y_nx < ye_q) begin
                    x_d     = x0_q;
                    y_d     = y_nx[nY-1:0];
                    write_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            x       <= '0;
            y       <= '0;
            color   <= '0;
            write   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            x       <= x_d;
            y       <= y_d;
            color   <= color_d;
            write   <= write_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_rect_painter.sv
// Bench for rect_painter: directed and random paints at 640x480 checked
// against a pixel-list model, plus one clipped paint at 160x120.
module tb_rect_painter;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, abort;
    logic [9:0] x0, w, x;
    logic [8:0] y0, h, y;
    logic [8:0] fill_color, color;
    logic       busy, done, write;

    logic       s_start, s_abort;
    logic [7:0] s_x0, s_w, s_x;
    logic [6:0] s_y0, s_h, s_y;
    logic [2:0] s_fill, s_color;
    logic       s_busy, s_done, s_write;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    rect_painter #(.RESOLUTION("640x480"), .COLOR_DEPTH(9)) dut (
        .clock(clock), .reset(reset), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .fill_color(fill_color), .abort(abort), .busy(busy), .done(done),
        .x(x), .y(y), .color(color), .write(write)
    );

    rect_painter #(.RESOLUTION("160x120"), .COLOR_DEPTH(3)) dut_s (
        .clock(clock), .reset(reset), .start(s_start), .x0(s_x0), .y0(s_y0), .w(s_w), .h(s_h),
        .fill_color(s_fill), .abort(s_abort), .busy(s_busy), .done(s_done),
        .x(s_x), .y(s_y), .color(s_color), .write(s_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Paint one rectangle on the 640x480 instance. abort_at/start_at name the
    // write index (1-based) on which abort or a stray start is raised; 0 = never.
    task automatic paint(input int px0, input int py0, input int pw, input int ph,
                         input int pc, input int abort_at, input int start_at);
        int ex[$];
        int ey[$];
        int xe, ye, n_exp, budget, cyc, wr, done_cyc;
        xe = (px0 + pw > 640) ? 640 : px0 + pw;
        ye = (py0 + ph > 480) ? 480 : py0 + ph;
        for (int yy = py0; yy < ye; yy++)
            for (int xx = px0; xx < xe; xx++) begin
                ex.push_back(xx);
                ey.push_back(yy);
            end
        n_exp = ex.size();
        if (abort_at != 0 && abort_at < n_exp) n_exp = abort_at;
        budget = ex.size() + 10;

        @(posedge clock); #1;
        x0 = 10'(px0); y0 = 9'(py0); w = 10'(pw); h = 9'(ph);
        fill_color = 9'(pc); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("clip_busy", 32'(busy), 1);
        chk("clip_write", 32'(write), 0);
        cyc = 1; wr = 0; done_cyc = -1;
        while (1) begin
            @(posedge clock); #1;
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (write === 1'b1) begin
                if (wr == 0) chk("first_write_cycle", cyc, 2);
                if (wr < ex.size()) begin
                    chk("pix_x", 32'(x), ex[wr]);
                    chk("pix_y", 32'(y), ey[wr]);
                end
                chk("pix_color", 32'(color), pc);
                wr++;
                if (wr == abort_at) abort = 1'b1;
                if (wr == start_at) begin
                    start = 1'b1;
                    x0 = '0; y0 = '0; w = 10'd50; h = 9'd50;
                end
            end
            if (done === 1'b1) done_cyc = cyc;
            if (busy !== 1'b1) break;
            if (cyc > budget) begin
                chk("timeout", cyc, budget);
                break;
            end
        end
        chk("write_count", wr, n_exp);
        if (abort_at != 0 && abort_at <= ex.size()) begin
            chk("abort_no_done", done_cyc, -1);
            chk("abort_idle_cycle", cyc, 2 + abort_at);
        end else begin
            chk("done_cycle", done_cyc, 2 + ex.size());
        end
        chk("idle_write", 32'(write), 0);
        chk("idle_done", 32'(done), 0);
    endtask

    int scyc, swr, sdone;
    int wr_seen;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; fill_color = '0;
        s_start = 1'b0; s_abort = 1'b0;
        s_x0 = '0; s_y0 = '0; s_w = '0; s_h = '0; s_fill = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_xyc", {x, y, color}, 0);
        chk("rst_s_busy", 32'(s_busy), 0);
        reset = 1'b0;

        paint(10, 20, 3, 2, 9'h1C0, 0, 0);
        paint(638, 478, 5, 5, 9'h03F, 0, 0);
        paint(5, 5, 0, 4, 9'h111, 0, 0);
        paint(5, 5, 4, 0, 9'h111, 0, 0);
        paint(700, 5, 4, 4, 9'h111, 0, 0);
        paint(100, 100, 10, 10, 9'h0AA, 4, 0);
        paint(200, 50, 2, 2, 9'h155, 0, 0);
        paint(30, 40, 6, 3, 9'h0F0, 0, 3);

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                paint($urandom_range(600, 700), $urandom_range(440, 500),
                      $urandom_range(0, 50), $urandom_range(0, 45), $urandom_range(0, 511), 0, 0);
            else
                paint($urandom_range(0, 639), $urandom_range(0, 479),
                      $urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 511), 0, 0);
        end

        // Reset in the middle of a paint
        @(posedge clock); #1;
        x0 = 10'd0; y0 = 9'd0; w = 10'd10; h = 9'd10; fill_color = 9'h1FF; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 20 && wr_seen < 3; i++) begin
            @(posedge clock); #1;
            if (write === 1'b1) wr_seen++;
        end
        chk("pre_rst_write", 32'(write), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_write", 32'(write), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_xyc", {x, y, color}, 0);
        @(posedge clock); #1;
        chk("held_rst_busy", 32'(busy), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_done", 32'(done), 0);
        paint(1, 2, 2, 2, 9'h003, 0, 0);

        // 160x120, 3-bit color: clipped to a single pixel
        @(posedge clock); #1;
        s_x0 = 8'd159; s_y0 = 7'd0; s_w = 8'd4; s_h = 7'd1; s_fill = 3'b101; s_start = 1'b1;
        scyc = 0; swr = 0; sdone = -1;
        while (scyc < 20) begin
            @(posedge clock); #1;
            scyc++;
            s_start = 1'b0;
            if (s_write === 1'b1) begin
                chk("s_first_cycle", scyc, 2);
                chk("s_pix_x", 32'(s_x), 159);
                chk("s_pix_y", 32'(s_y), 0);
                chk("s_color", 32'(s_color), 5);
                swr++;
            end
            if (s_done === 1'b1) sdone = scyc;
            if (scyc > 1 && s_busy !== 1'b1) break;
        end
        chk("s_write_count", swr, 1);
        chk("s_done_cycle", sdone, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
